// File: rtl/sorted_display.sv
// rtl/sorted_display.sv - captures sorted nibbles on start_display rise and scans them on a 4-digit 7-seg display
// Optional blink-on-new-data behaviour is enabled by defining NEW_DATA_BLINK_EN.
module sorted_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_HALF  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_display,
  input  logic [3:0] sorted_num0,
  input  logic [3:0] sorted_num1,
  input  logic [3:0] sorted_num2,
  input  logic [3:0] sorted_num3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       loaded
);

  localparam int DW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHOW, BLINK} state_t;

  state_t        state;
  logic          start_q;
  logic [3:0]    d0, d1, d2, d3;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          cap;
  logic          wrap;
  logic          blank;
  logic [3:0]    cur_an;
  logic [3:0]    cur_val;

  if (REFRESH_DIV < 2 || BLINK_HALF < 1) begin : g_illegal_params
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign cap  = start_display & ~start_q;
  assign wrap = (div == DW'(REFRESH_DIV - 1));
  assign dp   = 1'b1;

  // Leftmost digit (an[3]) shows the smallest value.
  always_comb begin
    cur_an  = 4'b1110;
    cur_val = d3;
    case (idx)
      2'd0: begin cur_an = 4'b1110; cur_val = d3; end
      2'd1: begin cur_an = 4'b1101; cur_val = d2; end
      2'd2: begin cur_an = 4'b1011; cur_val = d1; end
      default: begin cur_an = 4'b0111; cur_val = d0; end
    endcase
  end

`ifdef NEW_DATA_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] rounds;
  logic [1:0]    half;
  // Even half-periods of a blink are dark, odd ones scan normally.
  assign blank = (state == IDLE) || ((state == BLINK) && !half[0]);
`else
  assign blank = (state == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      d0      <= 4'h0;
      d1      <= 4'h0;
      d2      <= 4'h0;
      d3      <= 4'h0;
      div     <= '0;
      idx     <= 2'd0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      loaded  <= 1'b0;
`ifdef NEW_DATA_BLINK_EN
      rounds  <= '0;
      half    <= 2'd0;
`endif
    end else begin
      start_q <= start_display;
      loaded  <= cap;
      if (cap) begin
        d0 <= sorted_num0;
        d1 <= sorted_num1;
        d2 <= sorted_num2;
        d3 <= sorted_num3;
      end
      // Free-running scan: a capture never disturbs the slot timing.
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      an  <= blank ? 4'hF : cur_an;
      seg <= blank ? 7'h7F : hex7(cur_val);
`ifdef NEW_DATA_BLINK_EN
      if (cap) begin
        state  <= BLINK;
        rounds <= '0;
        half   <= 2'd0;
      end else if ((state == BLINK) && wrap && (idx == 2'd3)) begin
        if (rounds == BW'(BLINK_HALF - 1)) begin
          rounds <= '0;
          half   <= half + 2'd1;
          if (half == 2'd3) state <= SHOW;
        end else begin
          rounds <= rounds + 1'b1;
        end
      end
`else
      if (cap) state <= SHOW;
`endif
    end
  end

endmodule

// File: tb/tb_sorted_display.sv
// tb/tb_sorted_display.sv - self-checking bench for sorted_display (default build, REFRESH_DIV=4)
module tb_sorted_display;

  localparam int RDIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_display;
  logic [3:0] sorted_num0, sorted_num1, sorted_num2, sorted_num3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       loaded;

  always #5 clk = ~clk;

  sorted_display #(.REFRESH_DIV(RDIV), .BLINK_HALF(1)) dut (
    .clk(clk), .rst(rst), .start_display(start_display),
    .sorted_num0(sorted_num0), .sorted_num1(sorted_num1),
    .sorted_num2(sorted_num2), .sorted_num3(sorted_num3),
    .an(an), .seg(seg), .dp(dp), .loaded(loaded)
  );

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [3:0] v0, v1, v2, v3;
    logic [6:0] seg;
  } vec_t;

  // Reference model: time since reset determines the slot; captured values are an array.
  int unsigned m_n;
  bit          m_shown;
  logic [3:0]  m_vals [4];
  bit          m_prev;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  bit          e_loaded;

  int checks = 0;
  int fails  = 0;
  int loaded_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    if (rst) begin
      m_n = 0; m_shown = 0; m_prev = 0;
      for (int i = 0; i < 4; i++) m_vals[i] = 4'h0;
      e_an = 4'hF; e_seg = 7'h7F; e_loaded = 0;
    end else begin
      int slot;
      slot = (m_n / RDIV) % 4;
      if (m_shown) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = HEX[m_vals[3 - slot]];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
      e_loaded = start_display && !m_prev;
      if (e_loaded) begin
        m_vals[0] = sorted_num0; m_vals[1] = sorted_num1;
        m_vals[2] = sorted_num2; m_vals[3] = sorted_num3;
        m_shown = 1;
      end
      m_prev = start_display;
      m_n++;
    end
    @(posedge clk);
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'd1);
    check("loaded", 32'(loaded), 32'(e_loaded));
    if (loaded) loaded_cnt++;
  endtask

  task automatic set_nums(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    sorted_num0 = a; sorted_num1 = b; sorted_num2 = c; sorted_num3 = d;
  endtask

  vec_t vecs [16];
  logic [3:0] prev_an;
  int run;
  bit found;

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].v0 = 4'(i); vecs[i].v1 = 4'(i); vecs[i].v2 = 4'(i); vecs[i].v3 = 4'(i);
      vecs[i].seg = HEX[i];
    end

    // Reset, then idle blank
    rst = 1; start_display = 0; set_nums(0, 0, 0, 0);
    repeat (3) step();
    rst = 0;
    repeat (50) step();

    // First capture and scan
    set_nums(4'h1, 4'h3, 4'h7, 4'hC); start_display = 1;
    loaded_cnt = 0;
    repeat (20) step();
    check("t2_loaded_pulses", 32'(loaded_cnt), 32'd1);
    found = 0;
    prev_an = an;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (an != prev_an) found = 1;
    end
    check("t2_slot_boundary_seen", 32'(found), 32'd1);
    run = 1;
    prev_an = an;
    for (int i = 0; i < 8; i++) begin
      step();
      if (an == prev_an) run++;
      else break;
    end
    check("t2_digit_len", 32'(run), 32'(RDIV));

    // Held high: no recapture
    set_nums(4'hF, 4'hF, 4'hF, 4'hF);
    loaded_cnt = 0;
    repeat (20) step();
    check("t3_no_capture", 32'(loaded_cnt), 32'd0);

    // Mid-slot capture
    start_display = 0;
    step();
    for (int i = 0; i < 8 && (m_n % RDIV) != 1; i++) step();
    set_nums(4'h0, 4'h0, 4'hA, 4'hF); start_display = 1;
    prev_an = an;
    step();
    check("t4_no_anode_change", 32'(an), 32'(prev_an));
    repeat (20) step();

    // Reset mid-scan, stay blank
    rst = 1; start_display = 0;
    step();
    check("t5_reset_an", 32'(an), 32'hF);
    rst = 0;
    loaded_cnt = 0;
    repeat (20) step();
    check("t5_stays_blank", 32'(an), 32'hF);
    check("t5_no_load", 32'(loaded_cnt), 32'd0);

    // Hex decode table
    foreach (vecs[i]) begin
      start_display = 0;
      step();
      set_nums(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
      start_display = 1;
      step();
      step();
      check($sformatf("hex_%0d", i), 32'(seg), 32'(vecs[i].seg));
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) start_display = ~start_display;
      set_nums(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
